// File: rtl/spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : spi_regfile
// Brief    : SPI slave register bank with write lock, write counter, sticky
//            error flags and fast commands. Optional irq: SPI_REGFILE_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regfile #(
    parameter int                ADDR_W   = 3,
    parameter int                REG_W    = 8,
    parameter logic [REG_W-1:0]  CTRL_RST = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_W-1:0]                   reg_addr,
    input  logic [REG_W-1:0]                    reg_data_o,
    input  logic                                reg_data_o_vld,
    output logic [REG_W-1:0]                    reg_data_i,
    input  logic [5:0]                          fastcmd,
    input  logic                                fastcmd_vld,
    output logic [7:0]                          status,
    output logic [((2**ADDR_W)-2)*REG_W-1:0]    cfg_o,
    output logic                                irq
);

    localparam int         c_NREG    = 2**ADDR_W;
    localparam logic [5:0] c_FC_SRST = 6'h01;
    localparam logic [5:0] c_FC_CCNT = 6'h02;
    localparam logic [5:0] c_FC_CFLG = 6'h03;
    localparam logic [5:0] c_FC_UNLK = 6'h04;

    logic [REG_W-1:0] r_ctrl;
    logic [REG_W-1:0] r_wrcnt;
    logic [REG_W-1:0] r_gen [2:c_NREG-1];
    logic [REG_W-1:0] r_rdata;
    logic             r_wr_rej;
    logic             r_fc_unk;

    logic [REG_W-1:0] w_rdata;
    logic             w_wr_ok;
    logic             w_rej_set;
    logic             w_unk_set;
    logic             w_flag_clr;

    // A write colliding with a fast command is always dropped.
    assign w_wr_ok    = reg_data_o_vld & ~fastcmd_vld &
                        ((reg_addr == ADDR_W'(0)) |
                         ((reg_addr != ADDR_W'(1)) & ~r_ctrl[0]));
    assign w_rej_set  = reg_data_o_vld & ~w_wr_ok;
    assign w_unk_set  = fastcmd_vld & ((fastcmd == 6'h00) | (fastcmd > c_FC_UNLK));
    assign w_flag_clr = fastcmd_vld & ((fastcmd == c_FC_SRST) | (fastcmd == c_FC_CFLG));

    always_comb begin
        w_rdata = '0;
        case (reg_addr)
            ADDR_W'(0): w_rdata = r_ctrl;
            ADDR_W'(1): w_rdata = r_wrcnt;
            default:    w_rdata = r_gen[reg_addr];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl   <= CTRL_RST;
            r_wrcnt  <= '0;
            r_rdata  <= '0;
            r_wr_rej <= 1'b0;
            r_fc_unk <= 1'b0;
            for (int k = 2; k < c_NREG; k++) begin
                r_gen[k] <= '0;
            end
        end else begin
            r_rdata <= w_rdata;
            if (fastcmd_vld) begin
                case (fastcmd)
                    c_FC_SRST: begin
                        r_ctrl  <= CTRL_RST;
                        r_wrcnt <= '0;
                        for (int k = 2; k < c_NREG; k++) begin
                            r_gen[k] <= '0;
                        end
                    end
                    c_FC_CCNT: r_wrcnt   <= '0;
                    c_FC_UNLK: r_ctrl[0] <= 1'b0;
                    default: ;
                endcase
            end else if (w_wr_ok) begin
                if (reg_addr == ADDR_W'(0)) begin
                    r_ctrl <= reg_data_o;
                end else begin
                    r_gen[reg_addr] <= reg_data_o;
                end
                r_wrcnt <= r_wrcnt + REG_W'(1);
            end
            // Clear wins over a same-cycle set.
            r_wr_rej <= w_flag_clr ? 1'b0 : (r_wr_rej | w_rej_set);
            r_fc_unk <= w_flag_clr ? 1'b0 : (r_fc_unk | w_unk_set);
        end
    end

    assign reg_data_i = r_rdata;
    assign status     = {4'b0000, r_ctrl[1], r_fc_unk, r_wr_rej, r_ctrl[0]};

    generate
        for (genvar k = 2; k < c_NREG; k++) begin : g_cfg
            assign cfg_o[(k-2)*REG_W +: REG_W] = r_gen[k];
        end
    endgenerate

`ifdef SPI_REGFILE_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl[1] & (r_wr_rej | r_fc_unk);
        end
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regfile
// Brief    : Scoreboard bench for spi_regfile against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regfile;

    localparam int         ADDR_W = 3;
    localparam int         REG_W  = 8;
    localparam int         NREG   = 2**ADDR_W;
    localparam logic [7:0] CTRL_R = 8'h00;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [ADDR_W-1:0]          reg_addr = '0;
    logic [REG_W-1:0]           reg_data_o = '0;
    logic                       reg_data_o_vld = 1'b0;
    logic [REG_W-1:0]           reg_data_i;
    logic [5:0]                 fastcmd = '0;
    logic                       fastcmd_vld = 1'b0;
    logic [7:0]                 status;
    logic [(NREG-2)*REG_W-1:0]  cfg_o;
    logic                       irq;

    spi_regfile #(.ADDR_W(ADDR_W), .REG_W(REG_W), .CTRL_RST(CTRL_R)) dut (
        .clk(clk), .rst(rst), .reg_addr(reg_addr), .reg_data_o(reg_data_o),
        .reg_data_o_vld(reg_data_o_vld), .reg_data_i(reg_data_i),
        .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld), .status(status),
        .cfg_o(cfg_o), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [REG_W-1:0]          rd;
        logic [7:0]                st;
        logic [(NREG-2)*REG_W-1:0] cfg;
        logic                      irq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: index 0 = CTRL, 1 = WRCNT, 2.. = general registers.
    logic [REG_W-1:0] m_reg [NREG];
    logic             m_rej, m_unk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
        m_reg[0] = CTRL_R;
        m_rej = 1'b0;
        m_unk = 1'b0;
    endfunction

    function automatic logic [7:0] m_status();
        return {4'b0, m_reg[0][1], m_unk, m_rej, m_reg[0][0]};
    endfunction

    function automatic logic [(NREG-2)*REG_W-1:0] m_cfg();
        logic [(NREG-2)*REG_W-1:0] v = '0;
        for (int i = 2; i < NREG; i++) v[(i-2)*REG_W +: REG_W] = m_reg[i];
        return v;
    endfunction

    // One clock of stimulus; expected post-edge outputs go to the scoreboard.
    task automatic drive(input int a, input logic [7:0] d, input bit wv,
                         input logic [5:0] fc, input bit fv);
        exp_t e;
        bit   rej = 0, unk = 0, clr = 0;
        reg_addr       = ADDR_W'(a);
        reg_data_o     = d;
        reg_data_o_vld = wv;
        fastcmd        = fc;
        fastcmd_vld    = fv;
        e.rd = m_reg[a];
`ifdef SPI_REGFILE_IRQ_EN
        e.irq = m_reg[0][1] & (m_rej | m_unk);
`else
        e.irq = 1'b0;
`endif
        if (fv) begin
            rej = wv;
            if (fc == 6'h01) begin
                model_reset();
                clr = 1;
            end else if (fc == 6'h02) m_reg[1] = '0;
            else if (fc == 6'h03) clr = 1;
            else if (fc == 6'h04) m_reg[0][0] = 1'b0;
            else unk = 1;
        end else if (wv) begin
            if (a == 1 || (a >= 2 && m_reg[0][0])) rej = 1;
            else begin
                m_reg[a] = d;
                m_reg[1] = m_reg[1] + 1;
            end
        end
        if (clr) begin
            m_rej = 0;
            m_unk = 0;
        end else begin
            m_rej = m_rej | rej;
            m_unk = m_unk | unk;
        end
        e.st  = m_status();
        e.cfg = m_cfg();
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int a);
        drive(a, 8'h00, 0, 6'h00, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_rdata", 64'(reg_data_i), 64'(0));
        chk("rst_status", 64'(status), 64'({4'b0, CTRL_R[1], 2'b00, CTRL_R[0]}));
        chk("rst_cfg", 64'(cfg_o), 64'(0));
        chk("rst_irq", 64'(irq), 64'(0));
    endtask

    // Monitor: every cycle the DUT presents a new output set.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rdata", 64'(reg_data_i), 64'(e.rd));
            chk("status", 64'(status), 64'(e.st));
            chk("cfg", 64'(cfg_o), 64'(e.cfg));
            chk("irq", 64'(irq), 64'(e.irq));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;

        for (int i = 0; i < NREG; i++) idle(i);
        idle(0);

        drive(2, 8'hA5, 1, 6'h00, 0);
        idle(2); idle(1);

        drive(0, 8'h01, 1, 6'h00, 0);
        drive(5, 8'h3C, 1, 6'h00, 0);
        idle(5); idle(1);
        drive(0, 8'h00, 0, 6'h04, 1);
        drive(5, 8'h3C, 1, 6'h00, 0);
        idle(5); idle(1);

        drive(1, 8'h55, 1, 6'h00, 0);
        idle(1);
        drive(0, 8'h00, 0, 6'h3F, 1);
        drive(0, 8'h00, 0, 6'h03, 1);
        idle(0);

        drive(3, 8'h77, 1, 6'h02, 1);
        idle(3); idle(1);
        for (int i = 0; i < 255; i++) drive(2, 8'($urandom), 1, 6'h00, 0);
        idle(1);
        drive(4, 8'h12, 1, 6'h00, 0);
        idle(1);

        drive(0, 8'h02, 1, 6'h00, 0);
        drive(1, 8'h99, 1, 6'h00, 0);
        idle(0); idle(0);
        drive(0, 8'h00, 0, 6'h03, 1);
        idle(0); idle(0);

        // Collision with soft reset / flag clear must leave wr_rej low.
        drive(6, 8'hEE, 1, 6'h01, 1);
        drive(1, 8'h00, 1, 6'h00, 0);
        drive(7, 8'hEE, 1, 6'h03, 1);
        idle(7);

        for (int n = 0; n < 3000; n++) begin
            int   a  = int'($urandom_range(0, NREG-1));
            bit   wv = ($urandom_range(0, 1) == 1);
            bit   fv = ($urandom_range(0, 9) == 0);
            logic [5:0] fc;
            case ($urandom_range(0, 5))
                0: fc = 6'h01;
                1: fc = 6'h02;
                2: fc = 6'h03;
                3: fc = 6'h04;
                default: fc = 6'($urandom);
            endcase
            drive(a, 8'($urandom), wv, fc, fv);
            if (n == 1500) begin
                // Asynchronous reset between edges.
                rst = 1'b1;
                #1;
                check_reset_outputs();
                model_reset();
                #1;
                rst = 1'b0;
            end
        end
        idle(0);

        for (int t = 0; t < 10 && q.size() > 0; t++) @(negedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
